// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: NOP encoding, PC step,
// fetch FSM states and the fetched-word payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrived while ID was stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t d,
  output fetch_word_t q,
  output logic        full
);

  // Clear has priority so a flush always empties the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register: owns the PC, issues one outstanding
// imem request at a time, and handles stalls (via skid) and branch flushes.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic [15:0]       id_imm16
);

  fetch_state_e      state, state_next;
  logic [DATA_W-1:0] pc, pc_next, pc_plus4_c;
  logic              discard, discard_next;
  logic              id_valid_next;
  logic [DATA_W-1:0] id_instr_next, id_pc_plus4_next;
  logic              skid_load, skid_clear, skid_full;
  fetch_word_t       skid_d, skid_q;

  assign pc_plus4_c = pc + DATA_W'(PC_STEP);
  assign imem_addr  = pc;
  assign id_imm16   = id_instr[15:0];

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .q     (skid_q),
    .full  (skid_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= DATA_W'(NOP_INSTR);
      id_pc_plus4 <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      discard     <= discard_next;
      imem_req    <= (state_next == FETCH);
      id_valid    <= id_valid_next;
      id_instr    <= id_instr_next;
      id_pc_plus4 <= id_pc_plus4_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    discard_next     = discard;
    id_valid_next    = id_valid;
    id_instr_next    = id_instr;
    id_pc_plus4_next = id_pc_plus4;
    skid_load        = 1'b0;
    skid_clear       = 1'b0;
    skid_d.instr     = WORD_W'(imem_rdata);
    skid_d.pc_plus4  = WORD_W'(pc_plus4_c);

    if (branch_taken) begin
      // A request still in flight must have its eventual response dropped.
      state_next    = FETCH;
      pc_next       = branch_target;
      discard_next  = (state == FETCH) && !imem_valid;
      id_valid_next = 1'b0;
      id_instr_next = DATA_W'(NOP_INSTR);
      skid_clear    = 1'b1;
    end else begin
      case (state)
        IDLE: state_next = FETCH;
        FETCH: begin
          if (imem_valid && discard) begin
            discard_next = 1'b0;
            if (!stall) begin
              id_valid_next = 1'b0;
              id_instr_next = DATA_W'(NOP_INSTR);
            end
          end else if (imem_valid && stall) begin
            skid_load  = 1'b1;
            pc_next    = pc_plus4_c;
            state_next = HELD;
          end else if (imem_valid) begin
            id_valid_next    = 1'b1;
            id_instr_next    = imem_rdata;
            id_pc_plus4_next = pc_plus4_c;
            pc_next          = pc_plus4_c;
          end else if (!stall) begin
            id_valid_next = 1'b0;
            id_instr_next = DATA_W'(NOP_INSTR);
          end
        end
        HELD: begin
          if (!stall) begin
            id_valid_next    = skid_full;
            id_instr_next    = DATA_W'(skid_q.instr);
            id_pc_plus4_next = DATA_W'(skid_q.pc_plus4);
            skid_clear       = 1'b1;
            state_next       = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: hand-driven imem responses, checks after each edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [15:0] id_imm16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_stage #(.DATA_W(32), .PC_RESET(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_imm16      (id_imm16)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   word = 32'h2008_0005;
      32'h4:   word = 32'h2009_0007;
      32'h8:   word = 32'h200A_0009;
      32'hC:   word = 32'h200B_000B;
      default: word = 32'hAC00_0000 | a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);

    // IDLE -> FETCH
    @(negedge clk); reset = 1'b0;
    tick();
    chk("idle_to_fetch_req", 32'(imem_req), 32'd1);
    chk("idle_to_fetch_addr", imem_addr, 32'h0);
    chk("idle_to_fetch_valid", 32'(id_valid), 32'd0);

    // 1: zero-wait, one instruction per cycle
    @(negedge clk); imem_valid = 1'b1; imem_rdata = word(32'h0);
    tick();
    chk("t1a_instr", id_instr, 32'h2008_0005);
    chk("t1a_pc4", id_pc_plus4, 32'h4);
    chk("t1a_imm", 32'(id_imm16), 32'h0005);
    chk("t1a_addr", imem_addr, 32'h4);
    @(negedge clk); imem_rdata = word(32'h4);
    tick();
    chk("t1b_instr", id_instr, 32'h2009_0007);
    chk("t1b_pc4", id_pc_plus4, 32'h8);
    chk("t1b_imm", 32'(id_imm16), 32'h0007);
    chk("t1b_addr", imem_addr, 32'h8);

    // 2: stall while word@8 returns, hold 3 cycles
    @(negedge clk); stall = 1'b1; imem_rdata = word(32'h8);
    tick();
    chk("t2_hold_instr", id_instr, 32'h2009_0007);
    chk("t2_held_req", 32'(imem_req), 32'd0);
    chk("t2_pc_adv", imem_addr, 32'hC);
    @(negedge clk); imem_valid = 1'b0;
    tick(); tick();
    chk("t2_hold3_instr", id_instr, 32'h2009_0007);
    chk("t2_hold3_valid", 32'(id_valid), 32'd1);
    chk("t2_hold3_req", 32'(imem_req), 32'd0);
    @(negedge clk); stall = 1'b0;
    tick();
    chk("t2_rel_instr", id_instr, 32'h200A_0009);
    chk("t2_rel_pc4", id_pc_plus4, 32'hC);
    chk("t2_rel_req", 32'(imem_req), 32'd1);
    chk("t2_rel_addr", imem_addr, 32'hC);

    // 3: 2-wait memory, flush during the wait
    tick();
    chk("t3_bubble", 32'(id_valid), 32'd0);
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("t3_flush_addr", imem_addr, 32'h40);
    chk("t3_flush_valid", 32'(id_valid), 32'd0);
    chk("t3_flush_instr", id_instr, 32'h0);
    @(negedge clk); branch_taken = 1'b0; imem_valid = 1'b1; imem_rdata = word(32'hC);
    tick();
    chk("t3_stale_valid", 32'(id_valid), 32'd0);
    chk("t3_stale_addr", imem_addr, 32'h40);
    chk("t3_stale_req", 32'(imem_req), 32'd1);
    @(negedge clk); imem_valid = 1'b0;
    tick(); tick();
    chk("t3_wait_valid", 32'(id_valid), 32'd0);
    @(negedge clk); imem_valid = 1'b1; imem_rdata = word(32'h40);
    tick();
    chk("t3_tgt_valid", 32'(id_valid), 32'd1);
    chk("t3_tgt_instr", id_instr, 32'hAC00_0040);
    chk("t3_tgt_pc4", id_pc_plus4, 32'h44);
    chk("t3_tgt_addr", imem_addr, 32'h44);

    // 4: flush + stall + response in the same cycle
    @(negedge clk); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    imem_rdata = word(32'h44);
    tick();
    chk("t4_valid", 32'(id_valid), 32'd0);
    chk("t4_instr", id_instr, 32'h0);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_skid_empty", 32'(dut.u_skid.full), 32'd0);
    @(negedge clk); stall = 1'b0; branch_taken = 1'b0; imem_rdata = word(32'h100);
    tick();
    chk("t4_next_valid", 32'(id_valid), 32'd1);
    chk("t4_next_instr", id_instr, 32'hAC00_0100);
    chk("t4_next_pc4", id_pc_plus4, 32'h104);

    // 5: PC wrap at 32'hFFFF_FFFC (flush leaves a stale request at 0x104)
    @(negedge clk); imem_valid = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); branch_taken = 1'b0; imem_valid = 1'b1; imem_rdata = word(32'h104);
    tick();
    chk("t5_stale_valid", 32'(id_valid), 32'd0);
    chk("t5_stale_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); imem_rdata = word(32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_addr", imem_addr, 32'h0);
    chk("t5_wrap_pc4", id_pc_plus4, 32'h0);
    chk("t5_wrap_instr", id_instr, 32'hFFFF_FFFC);
    @(negedge clk); imem_rdata = word(32'h0);
    tick();
    chk("t5_post_addr", imem_addr, 32'h4);

    // 6: reset while request@4 is outstanding, late response ignored
    @(negedge clk); imem_valid = 1'b0; reset = 1'b1;
    tick();
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_instr", id_instr, 32'h0);
    chk("t6_rst_pc4", id_pc_plus4, 32'h0);
    @(negedge clk); reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_late_valid", 32'(id_valid), 32'd0);
    chk("t6_late_instr", id_instr, 32'h0);
    chk("t6_late_req", 32'(imem_req), 32'd1);
    chk("t6_late_addr", imem_addr, 32'h0);
    @(negedge clk); imem_rdata = word(32'h0);
    tick();
    chk("t6_restart_instr", id_instr, 32'h2008_0005);
    chk("t6_restart_pc4", id_pc_plus4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
